matmul_result_drain: RTL

Output-side collector for the systolic matrix multiplier. The array emits each result row as skewed column sums: column j of a row appears j cycles after column 0. This block realigns each row, buffers rows in a FIFO, and presents them on a valid/ready stream. It also gives the feeder a credit-style stall so that no row is lost.

---
 rtl/matmul_result_drain.sv | 125 ++++++++++++
 1 files changed

// File: rtl/matmul_result_drain.sv
// Realigns skewed column sums from the systolic array into whole rows, buffers
// them in a small FIFO and presents them on a valid/ready stream with a feeder stall.
module matmul_result_drain #(
    parameter int MATRIX_SIZE = 3,
    parameter int DATA_SIZE   = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  clear,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] in_sum,
    input  logic                                  in_valid,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] out_row,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  stall_req,
    output logic                                  overflow,
    output logic [15:0]                           row_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PD = MATRIX_SIZE - 1;
    localparam int OW = $clog2(FIFO_DEPTH + MATRIX_SIZE) + 1;

    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] aligned;
    logic                                  row_ready;
    logic [OW-1:0]                         inflight;
    logic [OW-1:0]                         occ;

    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]                         wr_ptr;
    logic [AW-1:0]                         rd_ptr;
    logic [CW-1:0]                         fifo_count;
    logic                                  full;
    logic                                  push;
    logic                                  pop;
    logic                                  drop;

    // Column j waits MATRIX_SIZE-1-j cycles so every column lines up with the last one.
    for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
        localparam int D = MATRIX_SIZE - 1 - j;
        if (D == 0) begin : g_pass
            assign aligned[j] = in_sum[j];
        end else begin : g_dly
            logic [DATA_SIZE-1:0] sr [D];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < D; k++) sr[k] <= '0;
                end else begin
                    sr[0] <= in_sum[j];
                    for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
                end
            end
            assign aligned[j] = sr[D-1];
        end
    end

    if (PD == 0) begin : g_nopipe
        assign row_ready = in_valid;
        assign inflight  = '0;
    end else begin : g_pipe
        logic [PD-1:0] v_pipe;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v_pipe <= '0;
            end else if (clear) begin
                v_pipe <= '0;
            end else begin
                v_pipe[0] <= in_valid;
                for (int k = 1; k < PD; k++) v_pipe[k] <= v_pipe[k-1];
            end
        end
        assign row_ready = v_pipe[PD-1];
        always_comb begin
            inflight = '0;
            for (int k = 0; k < PD; k++) inflight = inflight + OW'(v_pipe[k]);
        end
    end

    assign full      = (fifo_count == CW'(FIFO_DEPTH));
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = row_ready && (!full || pop);
    assign drop      = row_ready && full && !pop;
    assign out_row   = mem[rd_ptr];

    // Rows already in the deskew pipe count as occupied so an obedient feeder never overflows.
    assign occ       = OW'(fifo_count) + inflight;
    assign stall_req = (occ >= OW'(FIFO_DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            row_count  <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            row_count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                row_count <= row_count + 16'd1;
            end
            if (push && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (pop && !push) fifo_count <= fifo_count - CW'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (push && !clear) begin
            mem[wr_ptr] <= aligned;
        end
    end

endmodule
